// File: rtl/uart_pkg.sv
// Shared constants and types for the UART frame parser: sync byte, discard reasons,
// parser states and the 9-bit FIFO entry layout.
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_LEN_BAD  = 3'd1,
    ERR_CHK_BAD  = 3'd2,
    ERR_OVERFLOW = 3'd3,
    ERR_TIMEOUT  = 3'd4,
    ERR_LINE     = 3'd5
  } err_code_t;

  typedef enum logic [1:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CHK
  } state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/uart_rx_frame_parser_if.sv
// Bundle of the receiver byte stream, the payload output stream and frame status.
// The master modport is the parser's view; slave is the surrounding system's view.
interface uart_rx_frame_parser_if #(
  parameter int FIFO_DEPTH = 32
);
  import uart_pkg::*;

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_error;
  logic [7:0]    m_data;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;
  logic          frame_ok;
  logic          frame_err;
  logic [2:0]    err_code;
  logic [LW-1:0] fifo_level;

  modport master (
    input  rx_data, rx_valid, rx_error, m_ready,
    output m_data, m_last, m_valid, frame_ok, frame_err, err_code, fifo_level
  );

  modport slave (
    output rx_data, rx_valid, rx_error, m_ready,
    input  m_data, m_last, m_valid, frame_ok, frame_err, err_code, fifo_level
  );

endinterface

// File: rtl/uart_commit_fifo.sv
// Payload FIFO with a separate commit pointer: written bytes stay invisible to the
// reader until committed, and can be dropped by rolling the write pointer back.
module uart_commit_fifo
  import uart_pkg::*;
#(
  parameter int  DEPTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  fifo_entry_t wr_entry,
  input  logic        commit,
  input  logic        rollback,
  input  logic        rd_en,
  output fifo_entry_t rd_entry,
  output logic        rd_valid,
  output logic        full,
  output logic [PW-1:0] level
);

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] wr_ptr;
  fifo_entry_t   mem [DEPTH];

  // Uncommitted entries count toward fullness, so the space check uses wr_ptr.
  assign full     = (wr_ptr - rd_ptr) == PW'(DEPTH);
  assign rd_valid = commit_ptr != rd_ptr;
  assign level    = commit_ptr - rd_ptr;
  assign rd_entry = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      commit_ptr <= '0;
      wr_ptr     <= '0;
    end else begin
      if (rollback)
        wr_ptr <= commit_ptr;
      else if (wr_en && !full)
        wr_ptr <= wr_ptr + PW'(1);
      if (commit)
        commit_ptr <= wr_ptr;
      if (rd_en && rd_valid)
        rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full)
      mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Parses SYNC/LEN/PAYLOAD/CHK frames from the UART byte stream, buffers payload in a
// commit/rollback FIFO and releases only frames whose checksum sums to zero.
module uart_rx_frame_parser
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH     = 32,
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                    clk,
  input logic                    reset,
  uart_rx_frame_parser_if.master bus
);

  localparam int         LW        = $clog2(FIFO_DEPTH) + 1;
  localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t        state, state_nxt;
  logic [7:0]    len, len_nxt;
  logic [7:0]    sum, sum_nxt;
  logic [7:0]    count, count_nxt;
  logic [7:0]    chk_total;
  logic [TW-1:0] idle_cnt, idle_nxt;

  logic          wr_en;
  fifo_entry_t   wr_entry;
  logic          commit_req;
  logic          commit_q;
  logic          abort;
  err_code_t     abort_code;

  logic          frame_ok_q;
  logic          frame_err_q;
  err_code_t     err_code_q;

  fifo_entry_t   rd_entry;
  logic          rd_valid;
  logic          full;
  logic [LW-1:0] level;

  assign chk_total = sum + bus.rx_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_HUNT;
      len         <= '0;
      sum         <= '0;
      count       <= '0;
      idle_cnt    <= '0;
      commit_q    <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state       <= state_nxt;
      len         <= len_nxt;
      sum         <= sum_nxt;
      count       <= count_nxt;
      idle_cnt    <= idle_nxt;
      commit_q    <= commit_req;
      frame_ok_q  <= commit_req;
      frame_err_q <= abort;
      if (abort)
        err_code_q <= abort_code;
      else if (commit_req)
        err_code_q <= ERR_NONE;
    end
  end

  // Inside a frame rx_error beats a same-cycle byte, and a byte beats a same-cycle timeout.
  always_comb begin
    state_nxt  = state;
    len_nxt    = len;
    sum_nxt    = sum;
    count_nxt  = count;
    idle_nxt   = '0;
    wr_en      = 1'b0;
    wr_entry   = '0;
    commit_req = 1'b0;
    abort      = 1'b0;
    abort_code = ERR_NONE;

    if (state != S_HUNT) begin
      if (bus.rx_error) begin
        abort      = 1'b1;
        abort_code = ERR_LINE;
      end else if (bus.rx_valid) begin
        idle_nxt = '0;
      end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        abort      = 1'b1;
        abort_code = ERR_TIMEOUT;
      end else begin
        idle_nxt = idle_cnt + TW'(1);
      end
    end

    if (!abort && bus.rx_valid) begin
      case (state)
        S_HUNT: begin
          if (bus.rx_data == SYNC_BYTE)
            state_nxt = S_LEN;
        end
        S_LEN: begin
          if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN_B) begin
            abort      = 1'b1;
            abort_code = ERR_LEN_BAD;
          end else begin
            len_nxt   = bus.rx_data;
            sum_nxt   = bus.rx_data;
            count_nxt = 8'd0;
            state_nxt = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (full) begin
            abort      = 1'b1;
            abort_code = ERR_OVERFLOW;
          end else begin
            wr_en         = 1'b1;
            wr_entry.last = (count == len - 8'd1);
            wr_entry.data = bus.rx_data;
            sum_nxt       = sum + bus.rx_data;
            count_nxt     = count + 8'd1;
            if (count == len - 8'd1)
              state_nxt = S_CHK;
          end
        end
        S_CHK: begin
          if (chk_total == 8'd0)
            commit_req = 1'b1;
          else begin
            abort      = 1'b1;
            abort_code = ERR_CHK_BAD;
          end
          state_nxt = S_HUNT;
        end
        default: state_nxt = S_HUNT;
      endcase
    end

    if (abort) begin
      state_nxt = S_HUNT;
      idle_nxt  = '0;
    end
  end

  // Commit is delayed one cycle so the first byte appears the cycle after frame_ok.
  uart_commit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_entry (wr_entry),
    .commit   (commit_q),
    .rollback (abort),
    .rd_en    (bus.m_ready),
    .rd_entry (rd_entry),
    .rd_valid (rd_valid),
    .full     (full),
    .level    (level)
  );

  assign bus.m_data     = rd_entry.data;
  assign bus.m_last     = rd_entry.last;
  assign bus.m_valid    = rd_valid;
  assign bus.frame_ok   = frame_ok_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.err_code   = err_code_q;
  assign bus.fifo_level = level;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Scoreboard bench: stimulus pushes expected payload bytes and frame events into
// queues; a negedge monitor pops and compares whatever the parser presents.
module tb_uart_rx_frame_parser;
  import uart_pkg::*;

  localparam int FIFO_DEPTH     = 8;
  localparam int MAX_LEN        = 16;
  localparam int TIMEOUT_CYCLES = 50;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [8:0] exp_bytes[$];
  logic [3:0] exp_evts[$];
  byte_q_t    frame;
  int         waited;

  always #5 clk = ~clk;

  uart_rx_frame_parser_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  uart_rx_frame_parser #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_output(input string name, input int unsigned actual, input int unsigned expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input byte_q_t bs);
    foreach (bs[i]) begin
      bus.rx_data  = bs[i];
      bus.rx_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic apply_error();
    bus.rx_error = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_error = 1'b0;
  endtask

  task automatic expect_payload(input byte_q_t p);
    foreach (p[i])
      exp_bytes.push_back({(i == p.size() - 1), p[i]});
  endtask

  task automatic expect_event(input logic is_ok, input logic [2:0] code);
    exp_evts.push_back({is_ok, code});
  endtask

  task automatic wait_events(input int budget, input string name, output int n);
    n = 0;
    while (exp_evts.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_evts.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s events_pending actual=%0d required=0", name, exp_evts.size());
      exp_evts.delete();
    end
  endtask

  task automatic wait_bytes(input int budget, input string name);
    int n = 0;
    while (exp_bytes.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_bytes.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s bytes_pending actual=%0d required=0", name, exp_bytes.size());
      exp_bytes.delete();
    end
  endtask

  // Monitor: frame events, accepted bytes and output stability while stalled.
  initial begin
    logic [8:0] held;
    logic [8:0] want;
    logic [3:0] ev;
    logic       stall_prev;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check_output("stall_valid", bus.m_valid, 1);
          check_output("stall_data", {bus.m_last, bus.m_data}, held);
        end
        if (bus.m_valid && bus.m_ready) begin
          if (exp_bytes.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_byte actual=%0h required=none", {bus.m_last, bus.m_data});
          end else begin
            want = exp_bytes.pop_front();
            check_output("byte", {bus.m_last, bus.m_data}, want);
          end
        end
        if (bus.frame_ok || bus.frame_err) begin
          if (exp_evts.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_event actual=ok%0d/err%0d code=%0d required=none",
                     bus.frame_ok, bus.frame_err, bus.err_code);
          end else begin
            ev = exp_evts.pop_front();
            check_output("evt_ok", bus.frame_ok, ev[3]);
            check_output("evt_err", bus.frame_err, !ev[3]);
            check_output("evt_code", bus.err_code, ev[2:0]);
          end
        end
        stall_prev = bus.m_valid && !bus.m_ready;
        held       = {bus.m_last, bus.m_data};
      end
    end
  end

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.rx_error = 1'b0;
    bus.m_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_m_valid", bus.m_valid, 0);
    check_output("rst_m_last", bus.m_last, 0);
    check_output("rst_m_data", bus.m_data, 0);
    check_output("rst_frame_ok", bus.frame_ok, 0);
    check_output("rst_frame_err", bus.frame_err, 0);
    check_output("rst_err_code", bus.err_code, 0);
    check_output("rst_level", bus.fifo_level, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Good frame streamed straight through
    bus.m_ready = 1'b1;
    expect_event(1'b1, ERR_NONE);
    frame = '{8'h10, 8'h20};
    expect_payload(frame);
    frame = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE};
    apply_stimulus(frame);
    wait_events(20, "good_evt", waited);
    wait_bytes(20, "good_bytes");
    check_output("good_level", bus.fifo_level, 0);

    // Bad checksum then a good frame
    expect_event(1'b0, ERR_CHK_BAD);
    frame = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hCF};
    apply_stimulus(frame);
    wait_events(20, "chk_evt", waited);
    repeat (3) @(posedge clk);
    #1;
    check_output("chk_m_valid", bus.m_valid, 0);
    check_output("chk_code_held", bus.err_code, ERR_CHK_BAD);
    expect_event(1'b1, ERR_NONE);
    frame = '{8'h55};
    expect_payload(frame);
    frame = '{8'hA5, 8'h01, 8'h55, 8'hAA};
    apply_stimulus(frame);
    wait_events(20, "after_chk_evt", waited);
    wait_bytes(20, "after_chk_bytes");

    // Noise, zero length, oversize length, MAX_LEN accepted, line errors
    apply_error();
    expect_event(1'b0, ERR_LEN_BAD);
    frame = '{8'h33, 8'hA5, 8'h00};
    apply_stimulus(frame);
    wait_events(20, "len0_evt", waited);
    expect_event(1'b0, ERR_LEN_BAD);
    frame = '{8'hA5, 8'h11};
    apply_stimulus(frame);
    wait_events(20, "len17_evt", waited);
    expect_event(1'b0, ERR_LINE);
    frame = '{8'hA5, 8'h10, 8'h01};
    apply_stimulus(frame);
    apply_error();
    wait_events(20, "len16_line_evt", waited);
    expect_event(1'b0, ERR_LINE);
    frame = '{8'hA5, 8'h01};
    apply_stimulus(frame);
    apply_error();
    wait_events(20, "line_evt", waited);
    check_output("line_m_valid", bus.m_valid, 0);
    check_output("line_level", bus.fifo_level, 0);

    // Timeout, then gaps shorter than the limit are tolerated
    expect_event(1'b0, ERR_TIMEOUT);
    frame = '{8'hA5, 8'h03, 8'h11};
    apply_stimulus(frame);
    wait_events(200, "timeout_evt", waited);
    check_output("timeout_not_early", (waited >= TIMEOUT_CYCLES - 5), 1);
    check_output("timeout_m_valid", bus.m_valid, 0);
    check_output("timeout_level", bus.fifo_level, 0);
    expect_event(1'b1, ERR_NONE);
    frame = '{8'h55};
    expect_payload(frame);
    frame = '{8'hA5, 8'h01};
    apply_stimulus(frame);
    repeat (40) @(posedge clk);
    #1;
    frame = '{8'h55};
    apply_stimulus(frame);
    repeat (40) @(posedge clk);
    #1;
    frame = '{8'hAA};
    apply_stimulus(frame);
    wait_events(20, "slow_evt", waited);
    wait_bytes(20, "slow_bytes");

    // Overflow with a committed frame stalled in the FIFO
    bus.m_ready = 1'b0;
    expect_event(1'b1, ERR_NONE);
    frame = '{8'h01, 8'h02, 8'h03, 8'h04};
    expect_payload(frame);
    frame = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};
    apply_stimulus(frame);
    check_output("lat_frame_ok", bus.frame_ok, 1);
    check_output("lat_m_valid_early", bus.m_valid, 0);
    @(posedge clk);
    #1;
    check_output("lat_m_valid", bus.m_valid, 1);
    check_output("ovf_level_before", bus.fifo_level, 4);
    expect_event(1'b0, ERR_OVERFLOW);
    frame = '{8'hA5, 8'h05, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    apply_stimulus(frame);
    wait_events(20, "ovf_evt", waited);
    check_output("ovf_level_after", bus.fifo_level, 4);
    check_output("ovf_head", {bus.m_last, bus.m_data}, 9'h001);
    bus.m_ready = 1'b1;
    wait_bytes(20, "ovf_bytes");
    check_output("ovf_level_drained", bus.fifo_level, 0);

    // Two frames queued, then drained under random backpressure
    bus.m_ready = 1'b0;
    expect_event(1'b1, ERR_NONE);
    frame = '{8'h01, 8'h02, 8'h03};
    expect_payload(frame);
    frame = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF7};
    apply_stimulus(frame);
    expect_event(1'b1, ERR_NONE);
    frame = '{8'h7F};
    expect_payload(frame);
    frame = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    apply_stimulus(frame);
    wait_events(20, "bp_evt", waited);
    check_output("bp_level", bus.fifo_level, 4);
    for (int i = 0; i < 300 && exp_bytes.size() != 0; i++) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    bus.m_ready = 1'b1;
    wait_bytes(20, "bp_bytes");

    // Reset mid-payload clears committed data and the FSM
    bus.m_ready = 1'b0;
    expect_event(1'b1, ERR_NONE);
    frame = '{8'h10, 8'h20};
    expect_payload(frame);
    frame = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE};
    apply_stimulus(frame);
    wait_events(20, "pre_rst_evt", waited);
    frame = '{8'hA5, 8'h03, 8'h11};
    apply_stimulus(frame);
    #2;
    reset = 1'b0;
    #1;
    check_output("mid_rst_m_valid", bus.m_valid, 0);
    check_output("mid_rst_m_data", bus.m_data, 0);
    check_output("mid_rst_m_last", bus.m_last, 0);
    check_output("mid_rst_level", bus.fifo_level, 0);
    check_output("mid_rst_frame_ok", bus.frame_ok, 0);
    check_output("mid_rst_frame_err", bus.frame_err, 0);
    check_output("mid_rst_err_code", bus.err_code, 0);
    exp_bytes.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.m_ready = 1'b1;
    expect_event(1'b1, ERR_NONE);
    frame = '{8'h55};
    expect_payload(frame);
    frame = '{8'hA5, 8'h01, 8'h55, 8'hAA};
    apply_stimulus(frame);
    wait_events(20, "post_rst_evt", waited);
    wait_bytes(20, "post_rst_bytes");

    repeat (5) @(posedge clk);
    #1;
    check_output("final_bytes_left", exp_bytes.size(), 0);
    check_output("final_evts_left", exp_evts.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
